// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, BCD digit geometry,
// and the BCD increment helper used by the counter datapath.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_MAX  = 9;
  localparam int DATA_W     = DIGIT_W * NUM_DIGITS;

  // Returns {carry_out, incremented value}; carry_out marks the 9999 -> 0000 rollover.
  function automatic logic [DATA_W:0] bcd_inc(input logic [DATA_W-1:0] value);
    logic [DATA_W-1:0] result;
    logic              carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (value[i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(DIGIT_MAX)) begin
          result[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          result[i*DIGIT_W +: DIGIT_W] = value[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
          carry = 1'b0;
        end
      end
    end
    return {carry, result};
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, counting debouncer and a
// registered one-cycle press pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int DEBOUNCE = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The level flips on the DEBOUNCE-th consecutive mismatching cycle; any match restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop and clear buttons drive an
// IDLE/RUN/PAUSE FSM that gates a prescaled four-digit BCD counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int DEBOUNCE = 250000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] data,
  output logic              running,
  output logic              wrapped
);

  localparam int               PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  sw_state_t         state;
  sw_state_t         state_next;
  logic              start_press;
  logic              clear_press;
  logic [PRE_W-1:0]  presc;
  logic              tick;
  logic [DATA_W:0]   data_inc;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_start (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_start),
    .press (start_press)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clear),
    .press (clear_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
    end
  end

  // Clear has priority, so a coincident start press is simply dropped.
  always_comb begin
    state_next = state;
    if (clear_press) begin
      state_next = IDLE;
    end else if (start_press) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  assign tick     = (state == RUN) && (presc == PRE_LAST);
  assign data_inc = bcd_inc(data);

  // The prescaler only advances in RUN, so PAUSE keeps the partial tick period intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      data    <= '0;
      wrapped <= 1'b0;
    end else if (clear_press) begin
      presc   <= '0;
      data    <= '0;
      wrapped <= 1'b0;
    end else if (state == RUN) begin
      if (tick) begin
        presc   <= '0;
        data    <= data_inc[DATA_W-1:0];
        wrapped <= wrapped | data_inc[DATA_W];
      end else begin
        presc <= presc + PRE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEBOUNCE=3: press latency,
// glitch rejection, pause/resume, BCD rollover, clear priority and async reset.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int DEBOUNCE  = 3;
  localparam int PRESS_LAT = DEBOUNCE + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_start;
  logic        btn_clear;
  logic [15:0] data;
  logic        running;
  logic        wrapped;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .data      (data),
    .running   (running),
    .wrapped   (wrapped)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic c, input int cycles);
    btn_start = s;
    btn_clear = c;
    waitCycles(cycles);
  endtask

  // Bounded wait; a timeout shows up as a failed comparison against the target.
  task automatic waitForData(input logic [15:0] target, input int limit, input string tag);
    int n;
    n = 0;
    while (data !== target && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, data, target);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        total++;
        assert (data[i*4 +: 4] <= 4'd9) else begin
          bad++;
          $error("[TB] FAIL nibble%0d observed=%h required<=9", i, data[i*4 +: 4]);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    #3;
    checkOutput("reset_data", data, 16'h0000);
    checkOutput("reset_running", 16'(running), 16'h0000);
    checkOutput("reset_wrapped", 16'(wrapped), 16'h0000);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(10);
    checkOutput("idle_data", data, 16'h0000);
    checkOutput("idle_running", 16'(running), 16'h0000);

    for (int i = 0; i < 20; i++) begin
      btn_start = (i % 2 == 0);
      @(negedge clk);
      checkOutput("glitch_running", 16'(running), 16'h0000);
    end
    btn_start = 1'b1;
    waitCycles(PRESS_LAT - 1);
    checkOutput("hold_pre_running", 16'(running), 16'h0000);
    waitCycles(1);
    checkOutput("hold_running", 16'(running), 16'h0001);
    checkOutput("hold_data", data, 16'h0000);
    btn_start = 1'b0;

    // RUN entered at edge E0; ticks land on E0+4k.
    waitCycles(37);
    checkOutput("run_data_9", data, 16'h0009);
    btn_start = 1'b1;
    waitCycles(3);
    checkOutput("run_data_10", data, 16'h0010);
    waitCycles(2);
    checkOutput("pause_pre_running", 16'(running), 16'h0001);
    waitCycles(1);
    checkOutput("pause_running", 16'(running), 16'h0000);
    checkOutput("pause_data", data, 16'h0010);
    btn_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      waitCycles(10);
      checkOutput("pause_hold_data", data, 16'h0010);
      checkOutput("pause_hold_running", 16'(running), 16'h0000);
    end

    // Paused with prescaler at TICK_DIV-1, so the first RUN cycle ticks.
    btn_start = 1'b1;
    waitCycles(PRESS_LAT - 1);
    checkOutput("resume_pre_running", 16'(running), 16'h0000);
    waitCycles(1);
    checkOutput("resume_running", 16'(running), 16'h0001);
    checkOutput("resume_data", data, 16'h0010);
    btn_start = 1'b0;
    waitCycles(1);
    checkOutput("resume_tick1", data, 16'h0011);
    waitCycles(3);
    checkOutput("resume_hold", data, 16'h0011);
    waitCycles(1);
    checkOutput("resume_tick2", data, 16'h0012);

    waitForData(16'h0999, 5000, "reach_0999");
    waitCycles(3);
    checkOutput("hold_0999", data, 16'h0999);
    waitCycles(1);
    checkOutput("carry_1000", data, 16'h1000);

    waitForData(16'h9999, 40000, "reach_9999");
    waitCycles(3);
    checkOutput("hold_9999", data, 16'h9999);
    checkOutput("prewrap_wrapped", 16'(wrapped), 16'h0000);
    waitCycles(1);
    checkOutput("wrap_data", data, 16'h0000);
    checkOutput("wrap_wrapped", 16'(wrapped), 16'h0001);
    waitCycles(4);
    checkOutput("postwrap_data", data, 16'h0001);
    checkOutput("sticky_wrapped", 16'(wrapped), 16'h0001);

    applyStimulus(1'b1, 1'b1, PRESS_LAT - 1);
    checkOutput("both_pre_running", 16'(running), 16'h0001);
    waitCycles(1);
    checkOutput("both_running", 16'(running), 16'h0000);
    checkOutput("both_data", data, 16'h0000);
    checkOutput("both_wrapped", 16'(wrapped), 16'h0000);
    applyStimulus(1'b0, 1'b0, 8);
    checkOutput("both_idle_running", 16'(running), 16'h0000);
    checkOutput("both_idle_data", data, 16'h0000);

    applyStimulus(1'b1, 1'b0, PRESS_LAT);
    checkOutput("rerun_running", 16'(running), 16'h0001);
    btn_start = 1'b0;
    waitForData(16'h0042, 400, "reach_0042");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_data", data, 16'h0000);
    checkOutput("async_rst_running", 16'(running), 16'h0000);
    checkOutput("async_rst_wrapped", 16'(wrapped), 16'h0000);
    btn_start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(PRESS_LAT - 1);
    checkOutput("held_pre_running", 16'(running), 16'h0000);
    waitCycles(1);
    checkOutput("held_running", 16'(running), 16'h0001);
    checkOutput("held_data", data, 16'h0000);
    btn_start = 1'b0;
    waitCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 500000, clk cycles per count tick (50 MHz -> 100 Hz); legal >= 2.
REQ-002 Parameter DEBOUNCE, default 250000, consecutive stable cycles needed to accept a button level change; legal >= 1.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_start  input  1  raw start/stop push button, active-high, asynchronous to clk, bouncing.
REQ-006 btn_clear  input  1  raw clear push button, active-high, asynchronous to clk, bouncing.
REQ-007 data  output  16  four BCD digits for the hex display stage; [15:12] most significant, [3:0] least.
REQ-008 running  output  1  high while the FSM is in RUN.
REQ-009 wrapped  output  1  sticky flag, set when the count rolls over 9999 -> 0000.

Function
REQ-010 Each button path: 2-flop synchronizer, then debouncer; debounced level flips only after the synchronized input differs from it for DEBOUNCE consecutive cycles; any mismatch gap restarts the count.
REQ-011 Press event: one-cycle pulse on a 0->1 transition of the debounced level; a release generates no event.
REQ-012 Latency: a clean raw 0->1 held stable changes FSM state exactly DEBOUNCE+3 rising edges after the first edge sampling it high.
REQ-013 FSM states IDLE, RUN, PAUSE; start press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-014 Clear press: any state -> IDLE; data, prescaler and wrapped zeroed on the same edge.
REQ-015 Start and clear press on the same cycle: clear wins; the start press is discarded.
REQ-016 Prescaler counts 0..TICK_DIV-1 only in RUN; tick asserted when it holds TICK_DIV-1, then returns to 0.
REQ-017 PAUSE freezes prescaler and data; RUN resumes from the frozen prescaler value, with no lost or extra tick.
REQ-018 On tick, data increments in BCD: digit 9 -> 0 with carry to the next digit; no nibble ever holds A..F.
REQ-019 9999 + tick -> 0000 and wrapped set on the same edge; wrapped stays set until clear or reset.
REQ-020 data, running and wrapped are registered outputs; data changes on the edge after the tick-producing prescaler state.

Reset
REQ-021 rst_n low asynchronously forces: FSM IDLE, data 16'h0000, running 0, wrapped 0, prescaler 0, synchronizers 0, debounced levels 0, debounce counters 0.
REQ-022 Reset mid-count or mid-debounce discards all progress; a button held through reset release is seen as a new press once debounced.
REQ-023 Reset release is applied without a glitch on outputs; the first state change is possible only after a press completes debounce.

Structure
REQ-024 Package stopwatch_pkg holds the state encoding (IDLE, RUN, PAUSE), the BCD digit width (4), the digit count (4), and the BCD max digit (9).
REQ-025 One sub-module, btn_debounce (synchronizer, debouncer and press-pulse generator, parameter DEBOUNCE), is instantiated twice.
REQ-026 Prescaler width is derived from TICK_DIV; debounce counter width is derived from DEBOUNCE.

Verification (bench uses TICK_DIV=4, DEBOUNCE=3)
REQ-027 Reset asserted mid-run at data=0042 -> data=0000, running=0, wrapped=0 immediately, without waiting for a clk edge.
REQ-028 btn_start 1-cycle glitches every 2 cycles for 20 cycles, then held 1 -> no state change during glitches; running=1 exactly 6 edges after the stable high begins.
REQ-029 RUN for 40 cycles -> data=0010; start press -> PAUSE, data holds 0010 for 100 cycles; start press -> count resumes with no lost or extra tick.
REQ-030 Preload to 0999 by running -> the next tick gives 1000; continuing to 9999 -> the next tick gives 0000 with wrapped=1.
REQ-031 btn_start and btn_clear rise on the same cycle while in RUN -> IDLE, data=0000, running=0.
REQ-032 Every cycle, every data nibble <= 9 (assertion).
